// File: rtl/quat_pkg.sv
// Shared constants, entry type and the Q2.30 -> Q1.15 rescale helper used by
// the quaternion result serializer.
package quat_pkg;
  localparam int COMP_W   = 16;
  localparam int PROD_W   = 32;
  localparam int NUM_COMP = 4;

  typedef struct packed {
    logic [NUM_COMP-1:0][COMP_W-1:0] comp;   // comp[0] = r1 (w)
    logic                            sat;
  } quat_q15_t;

  typedef struct packed {
    logic              sat;
    logic [COMP_W-1:0] val;
  } rescale_t;

  // Round-half-up shift followed by a clamp to the signed 16-bit range.
  // The 33-bit sum cannot overflow even for 0x7FFFFFFF plus the rounding bias.
  function automatic rescale_t rescale(input logic [PROD_W-1:0] r, input int frac);
    logic signed [PROD_W:0] t;
    logic signed [PROD_W:0] rnd;
    rescale_t res;
    rnd = '0;
    if (frac > 0) rnd[frac-1] = 1'b1;
    t = $signed({r[PROD_W-1], r}) + rnd;
    t = t >>> frac;
    if (t > $signed((PROD_W+1)'(32767))) begin
      res.val = 16'h7FFF;
      res.sat = 1'b1;
    end else if (t < $signed((PROD_W+1)'(-32768))) begin
      res.val = 16'h8000;
      res.sat = 1'b1;
    end else begin
      res.val = t[COMP_W-1:0];
      res.sat = 1'b0;
    end
    return res;
  endfunction
endpackage

// File: rtl/quat_fifo.sv
// Synchronous quaternion FIFO; push when full and pop when empty are ignored.
module quat_fifo import quat_pkg::*; #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  quat_q15_t din,
  output quat_q15_t dout,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  quat_q15_t     mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(FIFO_DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/quat_result_serializer.sv
// Rescales a Hamilton-product quaternion to Q1.15, buffers it and streams the
// four components out one beat at a time with index/last/sat flags.
module quat_result_serializer import quat_pkg::*; #(
  parameter int FRAC_BITS  = 15,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] r1,
  input  logic [PROD_W-1:0] r2,
  input  logic [PROD_W-1:0] r3,
  input  logic [PROD_W-1:0] r4,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COMP_W-1:0] out_data,
  output logic [1:0]        out_idx,
  output logic              out_last,
  output logic              out_sat,
  output logic [7:0]        sat_count
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [NUM_COMP-1:0][PROD_W-1:0] r_in;
  rescale_t [NUM_COMP-1:0]         conv;
  logic [NUM_COMP-1:0]             sat_vec;
  quat_q15_t                       wr_q, fifo_dout, hold;
  logic                            push, load, full, empty;
  logic [2:0]                      n_sat;
  logic [8:0]                      sat_sum;
  logic [0:0]                      state;

  assign r_in = {r4, r3, r2, r1};

  for (genvar g = 0; g < NUM_COMP; g++) begin : g_conv
    assign conv[g]      = rescale(r_in[g], FRAC_BITS);
    assign wr_q.comp[g] = conv[g].val;
    assign sat_vec[g]   = conv[g].sat;
  end
  assign wr_q.sat = |sat_vec;

  always_comb begin
    n_sat = '0;
    for (int i = 0; i < NUM_COMP; i++) n_sat = n_sat + 3'(sat_vec[i]);
  end
  assign sat_sum = {1'b0, sat_count} + 9'(n_sat);

  assign in_ready = !full;
  assign push     = in_valid && !full;
  // Pop from IDLE, or back-to-back when the last beat of the current entry leaves.
  assign load = !empty && ((state == IDLE) ||
                           (out_ready && out_idx == 2'd3));

  quat_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (load),
    .din   (wr_q),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_count <= '0;
    else if (push) sat_count <= sat_sum[8] ? 8'hFF : sat_sum[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (load) begin
      state     <= EMIT;
      hold      <= fifo_dout;
      out_valid <= 1'b1;
      out_data  <= fifo_dout.comp[0];
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else if (state == EMIT && out_ready) begin
      if (out_idx != 2'd3) begin
        out_idx  <= out_idx + 2'd1;
        out_data <= hold.comp[out_idx + 2'd1];
        out_last <= (out_idx == 2'd2);
        out_sat  <= (out_idx == 2'd2) && hold.sat;
      end else begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        out_sat   <= 1'b0;
      end
    end
  end
endmodule
